// File: rtl/dp_alu_seq_if.sv
// Command, ALU and result bus of the data-processing sequencer.
// The sequencer sits on the slave side; the issuing stage, ALU and consumer sit on the master side.
interface dp_alu_seq_if;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned NZCV_W = 4;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [OP_W-1:0]   cmd_cond;
  logic              cmd_s;
  logic              cmd_long;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_shc;

  logic [DATA_W-1:0] alu_op1;
  logic [DATA_W-1:0] alu_op2;
  logic [OP_W-1:0]   alu_ctrl;
  logic              alu_c;
  logic [DATA_W-1:0] alu_result;
  logic [NZCV_W-1:0] alu_flags;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_wen;

  logic [NZCV_W-1:0] flags;
  logic              flags_ld;
  logic [NZCV_W-1:0] flags_in;

  modport slave (
    input  cmd_valid, cmd_op, cmd_cond, cmd_s, cmd_long, cmd_a, cmd_b, cmd_shc,
    output cmd_ready,
    output alu_op1, alu_op2, alu_ctrl, alu_c,
    input  alu_result, alu_flags,
    output res_valid, res_data, res_wen,
    input  res_ready,
    output flags,
    input  flags_ld, flags_in
  );

  modport master (
    output cmd_valid, cmd_op, cmd_cond, cmd_s, cmd_long, cmd_a, cmd_b, cmd_shc,
    input  cmd_ready,
    input  alu_op1, alu_op2, alu_ctrl, alu_c,
    output alu_result, alu_flags,
    input  res_valid, res_data, res_wen,
    output res_ready,
    input  flags,
    output flags_ld, flags_in
  );
endinterface

// File: rtl/dp_alu_seq.sv
// ARM data-processing sequencer: condition check, one or two ALU passes,
// result handshake and NZCV register maintenance.
module dp_alu_seq (
  input  logic        nGCLK,
  input  logic        nRESET,
  dp_alu_seq_if.slave bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned NZCV_W = 4;

  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h4;
  localparam logic [OP_W-1:0] OP_ADC = 4'h5;
  localparam logic [OP_W-1:0] OP_SBC = 4'h6;

  typedef enum logic [1:0] {IDLE, EXEC, LONG_HI, HOLD} state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                s_q, s_d;
  logic                long_q, long_d;
  logic                shc_q, shc_d;
  logic [WORD_W-1:0]   a_hi_q, a_hi_d;
  logic [WORD_W-1:0]   b_hi_q, b_hi_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_wen_q, res_wen_d;
  logic [NZCV_W-1:0]   flags_q, flags_d;
  logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
  logic [OP_W-1:0]     alu_ctrl_q, alu_ctrl_d;
  logic                alu_c_q, alu_c_d;

  // Only the low word and its carry-out come back from the ALU.
  logic unused_alu_hi_c;
  assign unused_alu_hi_c = ^bus.alu_result[DATA_W-1:WORD_W+1];

  function automatic logic cond_pass(input logic [OP_W-1:0] c, input logic [NZCV_W-1:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cy;
      4'h3:    cond_pass = !cy;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cy && !z;
      4'h9:    cond_pass = !cy || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // TST, TEQ, CMP, CMN: flags only, no destination write.
  function automatic logic is_cmp(input logic [OP_W-1:0] op);
    is_cmp = (op[3:2] == 2'b10);
  endfunction

  function automatic logic is_arith(input logic [OP_W-1:0] op);
    case (op)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB: is_arith = 1'b1;
      default:                                        is_arith = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    s_d         = s_q;
    long_d      = long_q;
    shc_d       = shc_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    cmd_ready_d = cmd_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_wen_d   = res_wen_q;
    flags_d     = flags_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_c_d     = alu_c_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d        = bus.cmd_op;
          s_d         = bus.cmd_s;
          long_d      = bus.cmd_long && (bus.cmd_op == OP_ADD || bus.cmd_op == OP_SUB);
          shc_d       = bus.cmd_shc;
          a_hi_d      = bus.cmd_a[DATA_W-1:WORD_W];
          b_hi_d      = bus.cmd_b[DATA_W-1:WORD_W];
          cmd_ready_d = 1'b0;
          res_data_d  = '0;
          res_wen_d   = 1'b0;
          if (cond_pass(bus.cmd_cond, flags_q)) begin
            // ALU inputs are registered here so they are stable for the whole EXEC cycle.
            state_d    = EXEC;
            res_wen_d  = !is_cmp(bus.cmd_op);
            alu_op1_d  = DATA_W'(bus.cmd_a[WORD_W-1:0]);
            alu_op2_d  = DATA_W'(bus.cmd_b[WORD_W-1:0]);
            alu_ctrl_d = bus.cmd_op;
            alu_c_d    = flags_q[1];
          end else begin
            state_d     = HOLD;
            res_valid_d = 1'b1;
          end
        end
      end
      EXEC: begin
        res_data_d[WORD_W-1:0] = bus.alu_result[WORD_W-1:0];
        if (long_q) begin
          // High pass chains the low-word carry through ADC/SBC.
          state_d    = LONG_HI;
          alu_op1_d  = DATA_W'(a_hi_q);
          alu_op2_d  = DATA_W'(b_hi_q);
          alu_ctrl_d = (op_q == OP_ADD) ? OP_ADC : OP_SBC;
          alu_c_d    = bus.alu_result[WORD_W];
        end else begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          if (s_q || is_cmp(op_q)) begin
            flags_d = is_arith(op_q) ? bus.alu_flags
                                     : {bus.alu_flags[3:2], shc_q, flags_q[0]};
          end
        end
      end
      LONG_HI: begin
        res_data_d[DATA_W-1:WORD_W] = bus.alu_result[WORD_W-1:0];
        state_d     = HOLD;
        res_valid_d = 1'b1;
        if (s_q) begin
          flags_d = {bus.alu_result[WORD_W-1],
                     (bus.alu_result[WORD_W-1:0] == '0) && (res_data_q[WORD_W-1:0] == '0),
                     bus.alu_flags[1:0]};
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A direct MSR write takes priority over any sequencer update.
    if (bus.flags_ld) flags_d = bus.flags_in;
  end

  always_ff @(posedge nGCLK) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      op_q        <= '0;
      s_q         <= 1'b0;
      long_q      <= 1'b0;
      shc_q       <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_wen_q   <= 1'b0;
      flags_q     <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_ctrl_q  <= '0;
      alu_c_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      s_q         <= s_d;
      long_q      <= long_d;
      shc_q       <= shc_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_wen_q   <= res_wen_d;
      flags_q     <= flags_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_c_q     <= alu_c_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_wen   = res_wen_q;
  assign bus.flags     = flags_q;
  assign bus.alu_op1   = alu_op1_q;
  assign bus.alu_op2   = alu_op2_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.alu_c     = alu_c_q;
endmodule

// File: tb/tb_dp_alu_seq.sv
// Bench for dp_alu_seq: combinational ARM ALU stand-in plus a whole-instruction
// reference model computed with plain 32/64-bit arithmetic.
module tb_dp_alu_seq;
  logic nGCLK;
  logic nRESET;
  int   errors;
  int   checks;
  logic [3:0] model_f;

  dp_alu_seq_if bif();

  dp_alu_seq dut (.nGCLK(nGCLK), .nRESET(nRESET), .bus(bif.slave));

  initial nGCLK = 1'b0;
  always #5 nGCLK = ~nGCLK;

  // ALU stand-in: low-word op with ARM carry semantics, carry-out on bit 32.
  logic [31:0] ax, ay, ar, ap, aq;
  logic [32:0] asum;
  logic        acin, aarith;
  always_comb begin
    ax = bif.alu_op1[31:0];
    ay = bif.alu_op2[31:0];
    ap = '0; aq = '0; acin = 1'b0; aarith = 1'b1; ar = '0;
    case (bif.alu_ctrl)
      4'h0, 4'h8: begin ar = ax & ay;  aarith = 1'b0; end
      4'h1, 4'h9: begin ar = ax ^ ay;  aarith = 1'b0; end
      4'hC:       begin ar = ax | ay;  aarith = 1'b0; end
      4'hD:       begin ar = ay;       aarith = 1'b0; end
      4'hE:       begin ar = ax & ~ay; aarith = 1'b0; end
      4'hF:       begin ar = ~ay;      aarith = 1'b0; end
      4'h2, 4'hA: begin ap = ax; aq = ~ay; acin = 1'b1; end
      4'h3:       begin ap = ay; aq = ~ax; acin = 1'b1; end
      4'h4, 4'hB: begin ap = ax; aq = ay;  acin = 1'b0; end
      4'h5:       begin ap = ax; aq = ay;  acin = bif.alu_c; end
      4'h6:       begin ap = ax; aq = ~ay; acin = bif.alu_c; end
      default:    begin ap = ay; aq = ~ax; acin = bif.alu_c; end
    endcase
    asum = {1'b0, ap} + {1'b0, aq} + 33'(acin);
    if (aarith) begin
      ar = asum[31:0];
      bif.alu_result = {31'h0, asum[32], ar};
      bif.alu_flags  = {ar[31], ar == 32'h0, asum[32], (ap[31] == aq[31]) && (ar[31] != ap[31])};
    end else begin
      bif.alu_result = {32'h0, ar};
      bif.alu_flags  = {ar[31], ar == 32'h0, bif.alu_c, 1'b0};
    end
  end

  typedef struct packed {
    logic        pass;
    logic        lng;
    logic        wen;
    logic [63:0] data;
    logic [3:0]  flags;
    logic [3:0]  lat;
    logic        lo_carry;
  } exp_t;

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] & ~f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return (c == 4'hF) ? 1'b0 : (base ^ c[0]);
  endfunction

  // Returns {C, V, result} of x + y + ci.
  function automatic logic [33:0] ref_add(input logic [31:0] x, y, input logic ci);
    logic [63:0] w; longint sv;
    w  = 64'(x) + 64'(y) + 64'(ci);
    sv = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    return {w[32], (sv > 64'sd2147483647) || (sv < -64'sd2147483648), w[31:0]};
  endfunction

  // Returns {C, V, result} of x - y - !ci, C meaning "no borrow".
  function automatic logic [33:0] ref_sub(input logic [31:0] x, y, input logic ci);
    logic br; longint sv; logic [31:0] r;
    br = ~ci;
    r  = x - y - 32'(br);
    sv = longint'($signed(x)) - longint'($signed(y)) - longint'(br);
    return {64'(x) >= 64'(y) + 64'(br), (sv > 64'sd2147483647) || (sv < -64'sd2147483648), r};
  endfunction

  function automatic exp_t ref_exec(input logic [3:0] op, cond, input logic s, lng,
                                    input logic [63:0] a, b, input logic shc, input logic [3:0] f);
    exp_t e; logic [33:0] cvr; logic logical; logic [64:0] w65; logic [63:0] r64; logic [32:0] lo;
    e = '0;
    e.pass  = ref_cond(cond, f);
    e.lng   = lng && (op == 4'h4 || op == 4'h2);
    e.flags = f;
    if (!e.pass) begin
      e.lat = 4'd1;
      return e;
    end
    e.wen = !(op inside {[4'h8:4'hB]});
    e.lat = e.lng ? 4'd3 : 4'd2;
    if (e.lng) begin
      if (op == 4'h4) begin
        w65 = {1'b0, a} + {1'b0, b};
        r64 = w65[63:0];
        lo  = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        e.lo_carry = lo[32];
        if (s) e.flags = {r64[63], r64 == 64'h0, w65[64], (a[63] == b[63]) && (r64[63] != a[63])};
      end else begin
        r64 = a - b;
        e.lo_carry = (a[31:0] >= b[31:0]);
        if (s) e.flags = {r64[63], r64 == 64'h0, a >= b, (a[63] != b[63]) && (r64[63] != a[63])};
      end
      e.data = r64;
      return e;
    end
    logical = 1'b1;
    cvr = '0;
    case (op)
      4'h0, 4'h8: cvr[31:0] = a[31:0] & b[31:0];
      4'h1, 4'h9: cvr[31:0] = a[31:0] ^ b[31:0];
      4'hC:       cvr[31:0] = a[31:0] | b[31:0];
      4'hD:       cvr[31:0] = b[31:0];
      4'hE:       cvr[31:0] = a[31:0] & ~b[31:0];
      4'hF:       cvr[31:0] = ~b[31:0];
      default:    logical = 1'b0;
    endcase
    case (op)
      4'h2, 4'hA: cvr = ref_sub(a[31:0], b[31:0], 1'b1);
      4'h3:       cvr = ref_sub(b[31:0], a[31:0], 1'b1);
      4'h4, 4'hB: cvr = ref_add(a[31:0], b[31:0], 1'b0);
      4'h5:       cvr = ref_add(a[31:0], b[31:0], f[1]);
      4'h6:       cvr = ref_sub(a[31:0], b[31:0], f[1]);
      4'h7:       cvr = ref_sub(b[31:0], a[31:0], f[1]);
      default:    ;
    endcase
    e.data = {32'h0, cvr[31:0]};
    if (s || !e.wen)
      e.flags = logical ? {cvr[31], cvr[31:0] == 32'h0, shc, f[0]}
                        : {cvr[31], cvr[31:0] == 32'h0, cvr[33], cvr[32]};
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [3:0] v);
    bif.flags_ld = 1'b1;
    bif.flags_in = v;
    @(negedge nGCLK);
    bif.flags_ld = 1'b0;
    check("flags_ld", 64'(bif.flags), 64'(v));
    model_f = v;
  endtask

  // Issue one command at a negedge in IDLE, follow it through to consumption.
  task automatic run_cmd(input logic [3:0] op, cond, input logic s, lng,
                         input logic [63:0] a, b, input logic shc,
                         input int hold, input logic ld_en, input logic [3:0] ld_val);
    exp_t e; int lat;
    e = ref_exec(op, cond, s, lng, a, b, shc, model_f);
    if (ld_en) e.flags = ld_val;
    check("cmd_ready_idle", 64'(bif.cmd_ready), 64'h1);
    bif.cmd_valid = 1'b1; bif.cmd_op = op; bif.cmd_cond = cond; bif.cmd_s = s;
    bif.cmd_long = lng; bif.cmd_a = a; bif.cmd_b = b; bif.cmd_shc = shc;
    @(posedge nGCLK);
    @(negedge nGCLK);
    bif.cmd_valid = 1'b0;
    lat = 1;
    while (lat < 8) begin
      if (lat == 1 && e.pass) begin
        check("exec_ctrl", 64'(bif.alu_ctrl), 64'(op));
        check("exec_op1", bif.alu_op1, {32'h0, a[31:0]});
        check("exec_c", 64'(bif.alu_c), 64'(model_f[1]));
      end
      if (lat == 2 && e.lng) begin
        check("hi_ctrl", 64'(bif.alu_ctrl), (op == 4'h4) ? 64'h5 : 64'h6);
        check("hi_c", 64'(bif.alu_c), 64'(e.lo_carry));
        check("hi_op2", bif.alu_op2, {32'h0, b[63:32]});
      end
      if (bif.res_valid === 1'b1) break;
      if (lat == 1 && ld_en) begin bif.flags_ld = 1'b1; bif.flags_in = ld_val; end
      @(negedge nGCLK);
      bif.flags_ld = 1'b0;
      lat++;
    end
    check("latency", 64'(lat), 64'(e.lat));
    check("res_data", bif.res_data, e.data);
    check("res_wen", 64'(bif.res_wen), 64'(e.wen));
    check("flags", 64'(bif.flags), 64'(e.flags));
    model_f = e.flags;
    for (int i = 0; i < hold; i++) begin
      @(negedge nGCLK);
      check("hold_valid", 64'(bif.res_valid), 64'h1);
      check("hold_data", bif.res_data, e.data);
      check("hold_wen", 64'(bif.res_wen), 64'(e.wen));
      check("hold_ready", 64'(bif.cmd_ready), 64'h0);
    end
    bif.res_ready = 1'b1;
    @(negedge nGCLK);
    bif.res_ready = 1'b0;
    check("consumed_valid", 64'(bif.res_valid), 64'h0);
  endtask

  initial begin
    errors = 0; checks = 0; model_f = 4'h0;
    bif.cmd_valid = 1'b0; bif.cmd_op = '0; bif.cmd_cond = '0; bif.cmd_s = 1'b0;
    bif.cmd_long = 1'b0; bif.cmd_a = '0; bif.cmd_b = '0; bif.cmd_shc = 1'b0;
    bif.res_ready = 1'b0; bif.flags_ld = 1'b0; bif.flags_in = '0;
    nRESET = 1'b0;
    repeat (2) @(negedge nGCLK);
    nRESET = 1'b1;
    check("rst_ready", 64'(bif.cmd_ready), 64'h1);
    check("rst_valid", 64'(bif.res_valid), 64'h0);
    check("rst_data", bif.res_data, 64'h0);
    check("rst_wen", 64'(bif.res_wen), 64'h0);
    check("rst_flags", 64'(bif.flags), 64'h0);
    check("rst_alu", {bif.alu_op1[31:0], bif.alu_op2[26:0], bif.alu_ctrl, bif.alu_c}, 64'h0);

    // ADDS overflow into the sign bit.
    run_cmd(4'h4, 4'hE, 1'b1, 1'b0, 64'h7FFF_FFFF, 64'h1, 1'b0, 0, 1'b0, 4'h0);
    check("adds_flags_const", 64'(bif.flags), 64'h9);
    // CMP equal, then EQ executes and NE is skipped.
    run_cmd(4'hA, 4'hE, 1'b0, 1'b0, 64'h5, 64'h5, 1'b0, 0, 1'b0, 4'h0);
    check("cmp_flags_const", 64'(bif.flags), 64'h6);
    run_cmd(4'hD, 4'h0, 1'b0, 1'b0, 64'h0, 64'h1234, 1'b0, 0, 1'b0, 4'h0);
    run_cmd(4'hD, 4'h1, 1'b0, 1'b0, 64'h0, 64'h1234, 1'b0, 0, 1'b0, 4'h0);
    // Long ADD carrying across the word boundary.
    run_cmd(4'h4, 4'hE, 1'b1, 1'b1, 64'h1_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b0, 4'h0);
    check("long_flags_const", 64'(bif.flags), 64'h0);
    // ANDS keeps preset V, takes C from the shifter.
    set_flags(4'b0001);
    run_cmd(4'h0, 4'hE, 1'b1, 1'b0, 64'hF0, 64'h0F, 1'b1, 0, 1'b0, 4'h0);
    check("ands_flags_const", 64'(bif.flags), 64'h7);
    // Back-pressure, MSR overriding ADDS, long SUB with borrow, long on a non-ADD/SUB op.
    run_cmd(4'h2, 4'hE, 1'b1, 1'b0, 64'h3, 64'h9, 1'b0, 5, 1'b0, 4'h0);
    run_cmd(4'h4, 4'hE, 1'b1, 1'b0, 64'hFFFF_FFFF, 64'h1, 1'b0, 0, 1'b1, 4'b1010);
    run_cmd(4'h2, 4'hE, 1'b1, 1'b1, 64'h5_0000_0000, 64'h1, 1'b0, 1, 1'b0, 4'h0);
    run_cmd(4'hC, 4'hE, 1'b1, 1'b1, 64'hA_0000_0003, 64'h5_0000_0004, 1'b0, 0, 1'b0, 4'h0);

    // Reset in LONG_HI discards the command.
    bif.cmd_valid = 1'b1; bif.cmd_op = 4'h4; bif.cmd_cond = 4'hE; bif.cmd_s = 1'b1;
    bif.cmd_long = 1'b1; bif.cmd_a = 64'h1_FFFF_FFFF; bif.cmd_b = 64'h1;
    @(posedge nGCLK);
    @(negedge nGCLK);
    bif.cmd_valid = 1'b0;
    @(negedge nGCLK);
    nRESET = 1'b0;
    @(negedge nGCLK);
    nRESET = 1'b1;
    check("mid_rst_valid", 64'(bif.res_valid), 64'h0);
    check("mid_rst_flags", 64'(bif.flags), 64'h0);
    check("mid_rst_ready", 64'(bif.cmd_ready), 64'h1);
    check("mid_rst_data", bif.res_data, 64'h0);
    model_f = 4'h0;

    // Randomised commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [63:0] ra, rb;
      if ($urandom_range(0, 3) == 0) set_flags(4'($urandom_range(0, 15)));
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 5) == 0) ? ra : {$urandom, $urandom};
      run_cmd(4'($urandom_range(0, 15)),
              ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dp_alu_seq.md
# dp_alu_seq

Data-processing sequencer for the execute stage. It accepts one ARM data-processing command at a time over a valid/ready handshake and evaluates the condition field against its own NZCV register. It then drives the 64-bit-port ALU for one pass, or for two passes for 64-bit long add/subtract. Results are returned over a second valid/ready handshake, and the architectural flags are updated under ARM rules.

## Interface
Parameters:
- none. Opcode encodings are the ARM data-processing values from `pardef`: AND=0, EOR=1, SUB=2, RSB=3, ADD=4, ADC=5, SBC=6, RSC=7, TST=8, TEQ=9, CMP=A, CMN=B, ORR=C, MOV=D, BIC=E, MVN=F.

Ports:
- nGCLK  in  1  clock, all state updates on rising edge
- nRESET  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_op  in  4  data-processing opcode
- cmd_cond  in  4  ARM condition field
- cmd_s  in  1  S bit (set flags)
- cmd_long  in  1  64-bit operation; legal only with ADD or SUB
- cmd_a  in  64  operand 1; upper word used only when cmd_long=1
- cmd_b  in  64  shifted operand 2; upper word used only when cmd_long=1
- cmd_shc  in  1  shifter carry-out, used for logical-op C flag
- alu_op1  out  64  to ALU op1
- alu_op2  out  64  to ALU shifted_op2
- alu_ctrl  out  4  to ALU control
- alu_c  out  1  to ALU carry input
- alu_result  in  64  from ALU result; bit 32 is carry-out
- alu_flags  in  4  from ALU flags {N,Z,C,V}
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  64  result; upper word is zero unless long
- res_wen  out  1  destination write required
- flags  out  4  architectural NZCV register
- flags_ld  in  1  direct flag write (MSR)
- flags_in  in  4  value for flags_ld

## Operation
- States: IDLE, EXEC, LONG_HI, HOLD.
- IDLE:
  - On cmd_valid&cmd_ready, latch the command and evaluate the condition against the current `flags`.
  - Conditions follow ARM encoding 0–E. Code F (NV) evaluates false.
  - Condition pass: go to EXEC. Condition fail: go to HOLD with res_wen=0, res_data=0, flags untouched.
- EXEC:
  - Drive alu_ctrl=op, alu_c=C flag, and low operand words zero-extended to 64 bits, so ALU bit 32 is the true carry.
  - Capture alu_result[31:0] into res_data[31:0].
  - Short op: go to HOLD. Long op: save the carry (alu_result[32]) and go to LONG_HI.
- LONG_HI:
  - Drive the high operand words zero-extended, with alu_ctrl=ADC for ADD or SBC for SUB, and alu_c=saved carry.
  - Capture into res_data[63:32]. Go to HOLD.
- HOLD:
  - res_valid=1, with res_data and res_wen stable.
  - On res_ready, go to IDLE.
- res_wen is 0 for TST, TEQ, CMP and CMN, and 1 for all other passing ops.
- Flag update happens at the edge leaving the final ALU pass. It applies when cmd_s=1, and always for TST, TEQ, CMP and CMN.
  - Arithmetic ops: NZCV = alu_flags.
  - Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): N and Z from alu_flags, C=cmd_shc, V unchanged.
  - Long: N=high-word bit 31, Z=(64-bit result==0), C and V from the LONG_HI pass.
- flags_ld writes flags_in in any state. If it coincides with a sequencer flag update, flags_ld wins.
- cmd_long with an opcode other than ADD or SUB is treated as short.
- When not in EXEC or LONG_HI, ALU outputs hold their last values.

## Timing
- Reset (nRESET=0 at an edge):
  - State is IDLE. cmd_ready=1 after the edge.
  - res_valid=0, res_data=0, res_wen=0, flags=0000.
  - alu_op1, alu_op2, alu_ctrl and alu_c are 0.
  - Reset mid-operation discards the command with no flag update and no result.
- Accept at edge N:
  - Short op: res_valid is high from N+2. Long op: from N+3. Condition fail: from N+1.
- The ALU is combinational. Its outputs are driven from registers in the EXEC and LONG_HI cycles and sampled at the end of that same cycle.
- flags reflects the update in the same cycle res_valid rises.
- Throughput: at most one command per 3 cycles short and 4 long, given res_ready=1 in the first HOLD cycle.
- res_valid stays high and all res_* outputs stay constant until res_ready is sampled high.
- cmd_ready is 0 in EXEC, LONG_HI and HOLD. A command cannot be accepted in the same cycle a result is consumed.

## Test plan
- Reset, then ADD, S=1, cond=AL, a=0x7FFFFFFF, b=1: res_data=0x80000000 at N+2, res_wen=1, flags=1001 (N, V).
- CMP, a=5, b=5 -> res_wen=0, flags=0110. Then MOVEQ b=0x1234 executes, and MOVNE is skipped: valid at N+1, res_wen=0, flags held.
- Long ADD, S=1, a=0x00000001_FFFFFFFF, b=0x00000000_00000001:
  - res_data=0x00000002_00000000 at N+3.
  - alu_ctrl=ADC with alu_c=1 in LONG_HI.
  - flags=0000.
- ANDS, a=0xF0, b=0x0F, cmd_shc=1, V preset via flags_ld=0001 -> result 0, flags=0111.
- Hold res_ready=0 for 5 cycles: res_* stable and cmd_ready=0. flags_ld during EXEC of an ADDS overrides the ALU flags. Assert nRESET in LONG_HI: next cycle IDLE, res_valid=0, flags=0000.
